// File: rtl/tt_seq_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SILLY_EXPECTED = 8'h31;
    localparam int         SETTLE_W       = 4;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that measures how long each input vector is held before sampling.
module settle_timer
    import tt_seq_pkg::*;
#(
    parameter logic [SETTLE_W-1:0] LOAD_VAL = 4'd1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    logic [SETTLE_W-1:0] cnt_q;
    logic [SETTLE_W-1:0] cnt_d;

    // Loaded with SETTLE-1 so that expire rises on the SETTLE-th DRIVE cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input combination of a small combinational unit, captures its
// truth table and compares it against a golden constant.
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int                       N_IN     = 3,
    parameter int                       SETTLE   = 2,
    parameter logic [(1<<N_IN)-1:0]     EXPECTED = SILLY_EXPECTED
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [N_IN-1:0]         drv,
    input  logic                    y,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<N_IN)-1:0]    tt,
    output logic                    match,
    output logic                    fail_valid,
    output logic [N_IN-1:0]         first_fail
);

    localparam int              TW       = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [TW-1:0]     tt_q, tt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              match_q, match_d;
    logic              fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]   first_fail_q, first_fail_d;
    logic              timer_load;
    logic              timer_expire;

    settle_timer #(
        .LOAD_VAL (SETTLE_W'(SETTLE - 1))
    ) u_settle_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .expire (timer_expire)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tt_d         = tt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        match_d      = match_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        timer_load   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = DRIVE;
                    idx_d        = '0;
                    tt_d         = '0;
                    busy_d       = 1'b1;
                    match_d      = 1'b0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    timer_load   = 1'b1;
                end
            end
            DRIVE: begin
                if (timer_expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                tt_d[idx_q] = y;
                if ((y != EXPECTED[idx_q]) && !fail_valid_q) begin
                    first_fail_d = idx_q;
                    fail_valid_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    // match is formed from tt_d so it is already valid during the done pulse.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    match_d = (tt_d == EXPECTED);
                end else begin
                    state_d    = DRIVE;
                    idx_d      = idx_q + 1'b1;
                    timer_load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            tt_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            match_q      <= 1'b0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tt_q         <= tt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            match_q      <= match_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end

    // The vector index doubles as the drive value, so drv never glitches between vectors.
    assign drv        = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tt         = tt_q;
    assign match      = match_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE=2 and SETTLE=1) checked
// every cycle against a timeline model of a sweep, plus literal spot checks.
module tb_truth_table_sequencer;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start_v [2];
    logic [7:0] ytab    [2];
    logic       y_w     [2];
    logic [2:0] drv_w   [2];
    logic [2:0] ff_w    [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       match_w [2];
    logic       fv_w    [2];
    logic [7:0] tt_w    [2];

    int n_vec    = 0;
    int n_bad    = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    // The function unit: y is the table entry selected by the driven vector.
    assign y_w[0] = ytab[0][drv_w[0]];
    assign y_w[1] = ytab[1][drv_w[1]];

    truth_table_sequencer #(.N_IN(3), .SETTLE(2), .EXPECTED(8'h31)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .drv(drv_w[0]), .y(y_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .tt(tt_w[0]), .match(match_w[0]),
        .fail_valid(fv_w[0]), .first_fail(ff_w[0])
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE(1), .EXPECTED(8'h31)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .drv(drv_w[1]), .y(y_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .tt(tt_w[1]), .match(match_w[1]),
        .fail_valid(fv_w[1]), .first_fail(ff_w[1])
    );

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    function automatic int settle_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    // Model: m_t counts cycles since the accepting edge (0 = idle). Vector v is
    // driven for t in v*(S+1)+1 .. (v+1)*(S+1); its sample is visible from
    // (v+1)*(S+1)+1; done is at 8*(S+1)+1.
    int         m_t    [2];
    logic [7:0] m_tab  [2];
    logic [7:0] m_tt   [2];
    logic [2:0] m_drv  [2];
    logic [2:0] m_ff   [2];
    logic       m_busy [2];
    logic       m_done [2];
    logic       m_match[2];
    logic       m_fv   [2];

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            int         s;
            int         done_t;
            int         nvis;
            logic [8:0] mask9;
            logic [7:0] mism;
            s      = settle_of(k);
            done_t = 8 * (s + 1) + 1;
            if (reset) begin
                m_t[k] = 0; m_tab[k] = '0; m_tt[k] = '0; m_drv[k] = '0; m_ff[k] = '0;
                m_busy[k] = 1'b0; m_done[k] = 1'b0; m_match[k] = 1'b0; m_fv[k] = 1'b0;
            end else begin
                if (m_t[k] == 0) begin
                    if (start_v[k]) begin
                        m_t[k]   = 1;
                        m_tab[k] = ytab[k];
                    end
                end else if (m_t[k] == done_t) begin
                    m_t[k] = 0;
                end else begin
                    m_t[k]++;
                end
                m_done[k] = (m_t[k] == done_t);
                m_busy[k] = (m_t[k] != 0) && !m_done[k];
                if (m_t[k] != 0) begin
                    nvis     = (m_t[k] - 1) / (s + 1);
                    m_drv[k] = (nvis > 7) ? 3'd7 : 3'(nvis);
                    mask9    = (9'd1 << nvis) - 9'd1;
                    m_tt[k]  = m_tab[k] & mask9[7:0];
                    mism     = (m_tab[k] ^ 8'h31) & mask9[7:0];
                    m_fv[k]  = (mism != 8'h00);
                    m_ff[k]  = 3'd0;
                    for (int b = 7; b >= 0; b--) begin
                        if (mism[b]) m_ff[k] = 3'(b);
                    end
                    m_match[k] = m_done[k] && (m_tab[k] == 8'h31);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check("drv",        k, 32'(drv_w[k]),   32'(m_drv[k]));
            check("busy",       k, 32'(busy_w[k]),  32'(m_busy[k]));
            check("done",       k, 32'(done_w[k]),  32'(m_done[k]));
            check("tt",         k, 32'(tt_w[k]),    32'(m_tt[k]));
            check("match",      k, 32'(match_w[k]), 32'(m_match[k]));
            check("fail_valid", k, 32'(fv_w[k]),    32'(m_fv[k]));
            check("first_fail", k, 32'(ff_w[k]),    32'(m_ff[k]));
        end
    end

    // One start pulse on dut0; optional re-pulses at relative cycles pa/pb.
    task automatic sweep0(input logic [7:0] tab, input int pa, input int pb,
                          output int done_cyc, output int n_done);
        int s_edge;
        int rel;
        done_cyc = -1;
        n_done   = 0;
        @(negedge clk);
        ytab[0]    = tab;
        start_v[0] = 1'b1;
        s_edge     = edge_cnt + 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rel = edge_cnt - s_edge + 1;
            if (done_w[0]) begin
                n_done++;
                if (done_cyc < 0) done_cyc = rel;
            end
            start_v[0] = (rel == pa) || (rel == pb);
        end
        start_v[0] = 1'b0;
        $display("sweep dut0 table=%02h done_cycle=%0d tt=%02h match=%0b fail_valid=%0b first_fail=%0d",
                 tab, done_cyc, tt_w[0], match_w[0], fv_w[0], ff_w[0]);
    endtask

    initial begin
        int dc;
        int nd;
        int s_edge;
        int rel;
        int dq[$];
        logic [7:0] rtab;

        start_v[0] = 1'b0; start_v[1] = 1'b0;
        ytab[0] = 8'h31;   ytab[1] = 8'h31;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_tt",   0, 32'(tt_w[0]),   32'h0);
        check("reset_busy", 0, 32'(busy_w[0]), 32'h0);
        check("reset_drv",  0, 32'(drv_w[0]),  32'h0);

        // Golden function.
        sweep0(8'h31, 0, 0, dc, nd);
        check("silly_done_cycle", 0, 32'(dc), 32'd25);
        check("silly_tt",    0, 32'(tt_w[0]),    32'h31);
        check("silly_match", 0, 32'(match_w[0]), 32'h1);
        check("silly_fv",    0, 32'(fv_w[0]),    32'h0);
        check("silly_drv_hold", 0, 32'(drv_w[0]), 32'h7);

        // y stuck at 0.
        sweep0(8'h00, 0, 0, dc, nd);
        check("zero_tt",    0, 32'(tt_w[0]),    32'h00);
        check("zero_match", 0, 32'(match_w[0]), 32'h0);
        check("zero_fv",    0, 32'(fv_w[0]),    32'h1);
        check("zero_ff",    0, 32'(ff_w[0]),    32'h0);

        // Inverted function.
        sweep0(8'hCE, 0, 0, dc, nd);
        check("inv_tt",    0, 32'(tt_w[0]),    32'hCE);
        check("inv_match", 0, 32'(match_w[0]), 32'h0);
        check("inv_ff",    0, 32'(ff_w[0]),    32'h0);

        // start re-pulsed while busy must be ignored.
        sweep0(8'h31, 5, 24, dc, nd);
        check("repulse_done_cycle", 0, 32'(dc), 32'd25);
        check("repulse_n_done",     0, 32'(nd), 32'd1);

        // Random tables with random idle gaps.
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rtab = 8'($urandom);
            sweep0(rtab, 0, 0, dc, nd);
            check("rand_done_cycle", 0, 32'(dc), 32'd25);
            check("rand_tt",         0, 32'(tt_w[0]), 32'(rtab));
        end

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        ytab[0] = 8'h31; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int i = 0; i < 50 && drv_w[0] != 3'd3; i++) @(negedge clk);
        check("reach_drv3", 0, 32'(drv_w[0]), 32'd3);
        #2 reset = 1'b1;
        #1;
        check("areset_drv",  0, 32'(drv_w[0]),  32'h0);
        check("areset_busy", 0, 32'(busy_w[0]), 32'h0);
        check("areset_tt",   0, 32'(tt_w[0]),   32'h0);
        check("areset_done", 0, 32'(done_w[0]), 32'h0);
        $display("async reset applied mid-sweep: drv=%0d busy=%0b tt=%02h", drv_w[0], busy_w[0], tt_w[0]);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sweep0(8'h31, 0, 0, dc, nd);
        check("post_reset_tt",    0, 32'(tt_w[0]),    32'h31);
        check("post_reset_match", 0, 32'(match_w[0]), 32'h1);

        // start held high on the SETTLE=1 instance.
        @(negedge clk);
        ytab[1] = 8'h31; start_v[1] = 1'b1;
        s_edge  = edge_cnt + 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            rel = edge_cnt - s_edge + 1;
            if (done_w[1]) begin
                dq.push_back(rel);
                check("held_match", 1, 32'(match_w[1]), 32'h1);
                $display("held start dut1 done_cycle=%0d tt=%02h match=%0b", rel, tt_w[1], match_w[1]);
            end
        end
        start_v[1] = 1'b0;
        check("held_n_done", 1, 32'(dq.size()), 32'd3);
        if (dq.size() >= 2) begin
            check("held_done0", 1, 32'(dq[0]), 32'd17);
            check("held_done1", 1, 32'(dq[1]), 32'd35);
        end
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
